instruction_fetch: RTL

//  Fetch stage directly upstream of the control unit.
//  - Holds the program counter and issues one instruction-memory read at a time.
//  - Registers the 32-bit word and presents it to the control unit under valid/ready.
//  - Takes the control unit's pcControl decode of the presented word to pick the next PC.

---
 rtl/instruction_fetch.sv | 117 +++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: PC, single-outstanding imem read, valid/ready hand-off to control unit
module instruction_fetch #(
    parameter int                ADDR_W   = 21,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic [2:0]        pc_control,
    input  logic [ADDR_W-1:0] target,
    input  logic              cond,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_WAIT    = 2'd1,
        ST_PRESENT = 2'd2,
        ST_HALT    = 2'd3
    } state_t;

    localparam logic [2:0] PCC_SEQ    = 3'd0;
    localparam logic [2:0] PCC_JUMP   = 3'd1;
    localparam logic [2:0] PCC_BRANCH = 3'd2;
    localparam logic [2:0] PCC_HALT   = 3'd3;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic              instr_valid_q, instr_valid_d;

    logic [ADDR_W-1:0] pc_plus1;
    logic [ADDR_W-1:0] next_pc;
    logic              handshake;

    // pc+1 wraps naturally at ADDR_W bits; the top address rolls to 0 silently
    assign pc_plus1  = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign handshake = instr_valid_q && instr_ready;

    // Next-PC select from the control unit's decode of the presented word
    always_comb begin
        next_pc = pc_plus1;
        case (pc_control)
            PCC_SEQ:    next_pc = pc_plus1;
            PCC_JUMP:   next_pc = target;
            PCC_BRANCH: next_pc = cond ? target : pc_plus1;
            PCC_HALT:   next_pc = pc_q;
            default:    next_pc = pc_plus1;
        endcase
    end

    // Fetch FSM next-state: one request, wait for data, present, then advance or halt
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        case (state_q)
            ST_FETCH: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Only a response seen here is accepted; stray rvalid elsewhere is dropped
                if (imem_rvalid) begin
                    instr_d       = imem_rdata;
                    instr_valid_d = 1'b1;
                    state_d       = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (handshake) begin
                    instr_valid_d = 1'b0;
                    pc_d          = next_pc;
                    state_d       = (pc_control == PCC_HALT) ? ST_HALT : ST_FETCH;
                end
            end
            ST_HALT: begin
                instr_valid_d = 1'b0;
            end
            default: begin
                state_d       = ST_FETCH;
                instr_valid_d = 1'b0;
            end
        endcase
    end

    // State registers; reset overrides any handshake or response in the same cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_FETCH;
            pc_q          <= RESET_PC;
            instr_q       <= 32'd0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    // The request is a one-cycle pulse tied to FETCH; held low while reset is asserted
    assign imem_req    = (state_q == ST_FETCH) && !reset;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign pc          = pc_q;
    assign halted      = (state_q == ST_HALT);

endmodule
